fetch_unit: RTL

Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core; upstream producer of the opcode/funct fields consumed by the decode-stage controller, and downstream consumer of its `pcSrcD`, `jump` and `clearD` outputs. It owns the PC and the next-PC selection (sequential, branch, jump), and talks to instruction memory over a request/valid handshake that tolerates wait states. It also handles redirects that arrive while a fetch is outstanding, and buffers an instruction that returns during a stall.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_next_pc.sv | 38 +++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: redirect target, sequential PC+4 and the value loaded into pcF.
module fetch_next_pc (
    input  logic [31:0] pc_f,
    input  logic [3:0]  pc_region,
    input  logic [25:0] jump_index,
    input  logic [31:0] pc_branch,
    input  logic [31:0] redir_pc,
    input  logic        jump,
    input  logic        sel_target,
    input  logic        sel_redir,
    input  logic        sel_seq,
    output logic [31:0] target,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_next
);

    assign pc_plus4 = pc_f + 32'd4;

    // Jump wins over branch; branch targets are word-aligned by masking.
    always_comb begin
        if (jump)
            target = {pc_region, jump_index, 2'b00};
        else
            target = pc_branch & ~32'd3;
    end

    always_comb begin
        if (sel_target)
            pc_next = target;
        else if (sel_redir)
            pc_next = redir_pc;
        else if (sel_seq)
            pc_next = pc_plus4;
        else
            pc_next = pc_f;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with wait-state tolerant imem handshake and the IF/ID register.
import fetch_pkg::*;

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        pcSrcD,
    input  logic        jump,
    input  logic        clearD,
    input  logic [31:0] pcBranchD,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemValid,
    input  logic [31:0] imemRdata,
    output logic [31:0] instrD,
    output logic [31:0] pcPlus4D,
    output logic        validD,
    output logic [5:0]  opCodeD,
    output logic [5:0]  funcD,
    output logic        fetchBusy
);

    fetch_state_t state;
    logic [31:0]  pcF;
    logic [31:0]  redirPc;
    logic [31:0]  holdBuf;
    logic [31:0]  target;
    logic [31:0]  pcPlus4F;
    logic [31:0]  pcNext;
    logic         redir;
    logic         flush;
    logic         deliver;
    logic [31:0]  deliverWord;
    logic         selTarget;
    logic         selRedir;
    logic         selSeq;

    assign redir     = (pcSrcD | jump) & validD & ~stallD;
    assign flush     = clearD & ~stallD;
    assign imemAddr  = pcF;
    assign fetchBusy = imemReq & ~imemValid;
    assign opCodeD   = instrD[31:26];
    assign funcD     = instrD[5:0];

    fetch_next_pc u_next_pc (
        .pc_f       (pcF),
        .pc_region  (pcPlus4D[31:28]),
        .jump_index (instrD[25:0]),
        .pc_branch  (pcBranchD),
        .redir_pc   (redirPc),
        .jump       (jump),
        .sel_target (selTarget),
        .sel_redir  (selRedir),
        .sel_seq    (selSeq),
        .target     (target),
        .pc_plus4   (pcPlus4F),
        .pc_next    (pcNext)
    );

    // PC selection and delivery decoded from the current state; the FSM below owns state changes.
    always_comb begin
        selTarget   = 1'b0;
        selRedir    = 1'b0;
        selSeq      = 1'b0;
        deliver     = 1'b0;
        deliverWord = NOP_INSTR;
        case (state)
            FETCH: begin
                if (redir) begin
                    selTarget = imemValid;
                end else if (imemValid && !stallF) begin
                    deliver     = 1'b1;
                    deliverWord = imemRdata;
                    selSeq      = 1'b1;
                end
            end
            DRAIN: selRedir = imemValid;
            HOLD: begin
                if (redir) begin
                    selTarget = 1'b1;
                end else if (!stallF) begin
                    deliver     = 1'b1;
                    deliverWord = holdBuf;
                    selSeq      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pcF     <= RESET_PC;
            redirPc <= '0;
            holdBuf <= '0;
            imemReq <= 1'b0;
        end else begin
            pcF <= pcNext;
            case (state)
                IDLE: begin
                    state   <= FETCH;
                    imemReq <= 1'b1;
                end
                FETCH: begin
                    if (redir) begin
                        if (!imemValid) begin
                            redirPc <= target;
                            state   <= DRAIN;
                        end
                    end else if (imemValid && stallF) begin
                        holdBuf <= imemRdata;
                        state   <= HOLD;
                        imemReq <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (imemValid)
                        state <= FETCH;
                end
                HOLD: begin
                    if (redir || !stallF) begin
                        state   <= FETCH;
                        imemReq <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    imemReq <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrD   <= NOP_INSTR;
            pcPlus4D <= '0;
            validD   <= 1'b0;
        end else if (!stallD) begin
            if (deliver && !flush) begin
                instrD   <= deliverWord;
                pcPlus4D <= pcPlus4F;
                validD   <= 1'b1;
            end else begin
                instrD   <= NOP_INSTR;
                pcPlus4D <= '0;
                validD   <= 1'b0;
            end
        end
    end

endmodule
